// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: op encodings and FSM states.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_out_reg.sv
// Result side of the sequencer: captures the ALU outputs, holds them behind a
// valid/ready handshake and counts completed handshakes (wrapping counter).
module alu_seq_out_reg
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_co,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_c,
   output logic             out_co,
   output logic [CNT_W-1:0] op_count
);

   logic             valid_q;
   logic [WIDTH-1:0] c_q;
   logic             co_q;
   logic [CNT_W-1:0] count_q;
   logic             handshake;

   assign handshake = valid_q & out_ready;

   // Capture on the EXEC edge; result stays put after the handshake until the next capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         c_q     <= '0;
         co_q    <= 1'b0;
         count_q <= '0;
      end else begin
         if (capture) begin
            valid_q <= 1'b1;
            c_q     <= alu_c;
            co_q    <= alu_co;
         end else if (handshake) begin
            valid_q <= 1'b0;
         end
         if (handshake) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = valid_q;
   assign out_c     = c_q;
   assign out_co    = co_q;
   assign op_count  = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshake wrapper around an external 4-bit ALU: accepts one request, holds the
// registered ALU inputs for a cycle, then presents the captured result.
// Optional feature: define ALU_ACCUM_EN to add in_acc (reuse last result as operand A).
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef ALU_ACCUM_EN
   input  logic             in_acc,
`endif
   output logic [1:0]       alu_s,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic             out_co,
   output logic             out_z,
   output logic [CNT_W-1:0] op_count
);

   state_t           state_q, state_d;
   logic             load;
   logic             capture;
   logic [1:0]       s_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] a_src;

`ifdef ALU_ACCUM_EN
   // Accumulate mode chains the previous captured result into operand A.
   assign a_src = in_acc ? out_c : in_a;
`else
   assign a_src = in_a;
`endif

   // Next-state and handshake decode.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      capture  = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            capture = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_DONE == state_q ? ST_IDLE : state_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and ALU input registers; inputs only change on acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            s_q <= in_op;
            a_q <= a_src;
            b_q <= in_b;
         end
      end
   end

   assign alu_s = s_q;
   assign alu_a = a_q;
   assign alu_b = b_q;

   alu_seq_out_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (capture),
      .alu_c     (alu_c),
      .alu_co    (alu_co),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_c     (out_c),
      .out_co    (out_co),
      .op_count  (op_count)
   );

   assign out_z = (out_c == '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU next to the DUT.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [1:0] in_op;
   logic [3:0] in_a, in_b;
   logic       in_acc;
   logic [1:0] alu_s;
   logic [3:0] alu_a, alu_b, alu_c;
   logic       alu_co;
   logic       out_valid, out_ready, out_co, out_z;
   logic [3:0] out_c;
   logic [7:0] op_count;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;
   logic [3:0] last_c = 4'h0;

   always #5 clk = ~clk;

   // External ALU: S selects ADD/SUB(a + ~b + 1)/AND/OR; Co is 0 for logic ops.
   logic [4:0] alu_wide;
   always_comb begin
      alu_wide = 5'd0;
      case (alu_s)
         OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:  alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
         OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
         default: alu_wide = {1'b0, alu_a | alu_b};
      endcase
   end
   assign alu_c  = alu_wide[3:0];
   assign alu_co = alu_wide[4];

   alu_op_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef ALU_ACCUM_EN
      .in_acc    (in_acc),
`endif
      .alu_s     (alu_s),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c     (alu_c),
      .alu_co    (alu_co),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_co    (out_co),
      .out_z     (out_z),
      .op_count  (op_count)
   );

   // Reference result {co, c} from plain integer arithmetic; SUB carry means "no borrow".
   function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
      int ia = int'(a);
      int ib = int'(b);
      logic [4:0] r;
      case (op)
         OP_ADD:  r = 5'(ia + ib);
         OP_SUB:  r = {(ia >= ib) ? 1'b1 : 1'b0, 4'(ia - ib)};
         OP_AND:  r = {1'b0, a & b};
         default: r = {1'b0, a | b};
      endcase
      return r;
   endfunction

   // One full transaction with out_ready high; checks every phase of its timing.
   task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic acc, input string tag);
      logic [3:0] a_eff;
      logic [4:0] r;
      a_eff = acc ? last_c : a;
      r = ref_alu(op, a_eff, b);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; out_ready = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++; $display("FAIL %s in_ready_idle: got %b expected 1", tag, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_acc = 1'b0;
      n_checks++;
      if (alu_s !== op || alu_a !== a_eff || alu_b !== b) begin
         n_errors++;
         $display("FAIL %s alu_inputs: got s=%0h a=%0h b=%0h expected s=%0h a=%0h b=%0h",
                  tag, alu_s, alu_a, alu_b, op, a_eff, b);
      end
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL %s exec_flags: got rdy=%b vld=%b expected rdy=0 vld=0",
                  tag, in_ready, out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_c !== r[3:0] || out_co !== r[4]
          || out_z !== (r[3:0] == 4'h0)) begin
         n_errors++;
         $display("FAIL %s result: got v=%b c=%0h co=%b z=%b expected v=1 c=%0h co=%b z=%b",
                  tag, out_valid, out_c, out_co, out_z, r[3:0], r[4], (r[3:0] == 4'h0));
      end
      last_c = r[3:0];
      exp_cnt = (exp_cnt + 1) % 256;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 8'(exp_cnt)) begin
         n_errors++;
         $display("FAIL %s after_consume: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=%0d",
                  tag, out_valid, in_ready, op_count, exp_cnt);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_acc = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      last_c = 4'h0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_flags: got rdy=%b vld=%b cnt=%0d expected rdy=1 vld=0 cnt=0",
                  in_ready, out_valid, op_count);
      end
      n_checks++;
      if (alu_s !== 2'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || out_c !== 4'd0
          || out_co !== 1'b0 || out_z !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_data: got s=%0h a=%0h b=%0h c=%0h co=%b z=%b expected 0 0 0 0 0 1",
                  alu_s, alu_a, alu_b, out_c, out_co, out_z);
      end
   endtask

   task automatic test_directed();
      run_op(OP_ADD, 4'd7, 4'd9, 1'b0, "add_7_9");
      run_op(OP_SUB, 4'd5, 4'd3, 1'b0, "sub_5_3");
      run_op(OP_AND, 4'hC, 4'h6, 1'b0, "and_c_6");
      run_op(OP_OR,  4'h9, 4'h4, 1'b0, "or_9_4");
      run_op(OP_SUB, 4'd2, 4'd6, 1'b0, "sub_borrow");
   endtask

   // Result must hold under backpressure and new requests must be ignored meanwhile.
   task automatic test_hold();
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_SUB; in_a = 4'd9; in_b = 4'd4; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = OP_OR; in_a = 4'($urandom_range(0, 15)); in_b = 4'hF;
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_c !== 4'd5 || in_ready !== 1'b0
             || alu_a !== 4'd9 || alu_s !== OP_SUB) begin
            n_errors++;
            $display("FAIL hold_%0d: got v=%b c=%0h rdy=%b a=%0h s=%0h expected 1 5 0 9 1",
                     i, out_valid, out_c, in_ready, alu_a, alu_s);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      exp_cnt = (exp_cnt + 1) % 256;
      last_c = 4'd5;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 8'(exp_cnt)
          || out_c !== 4'd5) begin
         n_errors++;
         $display("FAIL hold_release: got v=%b rdy=%b cnt=%0d c=%0h expected 0 1 %0d 5",
                  out_valid, in_ready, op_count, out_c, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      in_valid = 1'b1; in_op = OP_ADD; in_a = 4'd3; in_b = 4'd3; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 8'd0 || out_c !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_mid: got v=%b rdy=%b cnt=%0d c=%0h expected 0 1 0 0",
                  out_valid, in_ready, op_count, out_c);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_hold: got v=%b expected 0", out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      last_c = 4'h0;
   endtask

   task automatic test_back_to_back();
      logic acc;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         acc = 1'b0;
`ifdef ALU_ACCUM_EN
         acc = 1'($urandom_range(0, 1));
`endif
         run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), acc, "b2b");
      end
      n_checks++;
      if (op_count !== 8'd0) begin
         n_errors++;
         $display("FAIL count_wrap: got %0d expected 0", op_count);
      end
   endtask

`ifdef ALU_ACCUM_EN
   task automatic test_accum();
      apply_reset();
      run_op(OP_ADD, 4'd3, 4'd4, 1'b0, "acc_seed");
      run_op(OP_ADD, 4'($urandom_range(0, 15)), 4'd2, 1'b1, "acc_add");
      n_checks++;
      if (out_c !== 4'd9) begin
         n_errors++;
         $display("FAIL acc_result: got %0h expected 9", out_c);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = 4'd0; in_b = 4'd0;
      in_acc = 1'b0; out_ready = 1'b0;
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef ALU_ACCUM_EN
      test_accum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

endmodule
